// File: rtl/divider2_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | divider2_if : request/remainder-stage bundle for the divider2 controller   |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
interface divider2_if;
  logic        startEn;
  logic        signedOp;
  logic [31:0] dividendIn;
  logic [31:0] divisorIn;
  logic        wasNegative;
  logic        remainderEn;
  logic [1:0]  remainderSel;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic [31:0] quotient;
  logic        busy;
  logic        done;
  logic        divByZero;

  modport master (
    output startEn, signedOp, dividendIn, divisorIn, wasNegative,
    input  remainderEn, remainderSel, dividend, divisor, quotient,
           busy, done, divByZero
  );

  modport slave (
    input  startEn, signedOp, dividendIn, divisorIn, wasNegative,
    output remainderEn, remainderSel, dividend, divisor, quotient,
           busy, done, divByZero
  );
endinterface
`default_nettype wire

// File: rtl/divider2_control.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | divider2_control : sequencer for the 32-iteration restoring divider        |
// | Revision         : 1.0                                                     |
// +----------------------------------------------------------------------------+
module divider2_control (
  input  wire logic   clk,
  input  wire logic   reset,
  divider2_if.slave   bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOOP  = 2'd1,
    S_FIXUP = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [1:0] RESET_REMAINDER      = 2'd0;
  localparam logic [1:0] NEG_REMAINDER        = 2'd1;
  localparam logic [1:0] SHIFTED_REMAINDER    = 2'd2;
  localparam logic [1:0] SUBTRACTED_REMAINDER = 2'd3;

  state_t      state_q,    state_d;
  logic [4:0]  count_q,    count_d;
  logic [31:0] dividend_q, dividend_d;
  logic [31:0] divisor_q,  divisor_d;
  logic [31:0] quotient_q, quotient_d;
  logic        neg_quo_q,  neg_quo_d;
  logic        neg_rem_q,  neg_rem_d;
  logic        busy_q,     busy_d;
  logic        done_q,     done_d;
  logic        dbz_q,      dbz_d;
  logic        rem_en;
  logic [1:0]  rem_sel;
  logic        divisor_zero;

  assign divisor_zero = (bus.divisorIn == 32'd0);

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    dividend_d = dividend_q;
    divisor_d  = divisor_q;
    quotient_d = quotient_q;
    neg_quo_d  = neg_quo_q;
    neg_rem_d  = neg_rem_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    dbz_d      = dbz_q;
    rem_en     = 1'b0;
    rem_sel    = RESET_REMAINDER;

    case (state_q)
      S_IDLE: begin
        if (bus.startEn) begin
          dividend_d = (bus.signedOp && bus.dividendIn[31]) ? -bus.dividendIn : bus.dividendIn;
          divisor_d  = (bus.signedOp && bus.divisorIn[31])  ? -bus.divisorIn  : bus.divisorIn;
          // A zero divisor must leave the all-ones quotient un-negated.
          neg_quo_d  = bus.signedOp & (bus.dividendIn[31] ^ bus.divisorIn[31]) & ~divisor_zero;
          neg_rem_d  = bus.signedOp & bus.dividendIn[31];
          dbz_d      = divisor_zero;
          quotient_d = 32'd0;
          count_d    = 5'd0;
          busy_d     = 1'b1;
          rem_en     = 1'b1;
          rem_sel    = RESET_REMAINDER;
          state_d    = S_LOOP;
        end
      end
      S_LOOP: begin
        rem_en     = 1'b1;
        rem_sel    = bus.wasNegative ? SHIFTED_REMAINDER : SUBTRACTED_REMAINDER;
        quotient_d = {quotient_q[30:0], ~bus.wasNegative};
        dividend_d = {dividend_q[30:0], 1'b0};
        count_d    = count_q + 5'd1;
        if (count_q == 5'd31) begin
          state_d = S_FIXUP;
        end
      end
      S_FIXUP: begin
        if (neg_quo_q) begin
          quotient_d = -quotient_q;
        end
        if (neg_rem_q) begin
          rem_en  = 1'b1;
          rem_sel = NEG_REMAINDER;
        end
        done_d  = 1'b1;
        state_d = S_DONE;
      end
      S_DONE: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      count_q    <= 5'd0;
      dividend_q <= 32'd0;
      divisor_q  <= 32'd0;
      quotient_q <= 32'd0;
      neg_quo_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      dbz_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      dividend_q <= dividend_d;
      divisor_q  <= divisor_d;
      quotient_q <= quotient_d;
      neg_quo_q  <= neg_quo_d;
      neg_rem_q  <= neg_rem_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      dbz_q      <= dbz_d;
    end
  end

  assign bus.remainderEn  = rem_en;
  assign bus.remainderSel = rem_sel;
  assign bus.dividend     = dividend_q;
  assign bus.divisor      = divisor_q;
  assign bus.quotient     = quotient_q;
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.divByZero    = dbz_q;

endmodule
`default_nettype wire

// File: tb/tb_divider2_control.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_divider2_control : scoreboard bench with a behavioural remainder stage  |
// | Revision            : 1.0                                                  |
// +----------------------------------------------------------------------------+
module tb_divider2_control;

  logic clk = 1'b0;
  logic reset;
  divider2_if bus ();

  divider2_control dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Remainder stage: the register the controller steers.
  logic [31:0] rem;
  assign bus.wasNegative = ({rem, bus.dividend[31]} < {1'b0, bus.divisor});

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rem <= 32'd0;
    end else if (bus.remainderEn) begin
      case (bus.remainderSel)
        2'd0: rem <= 32'd0;
        2'd1: rem <= -rem;
        2'd2: rem <= {rem[30:0], bus.dividend[31]};
        2'd3: rem <= {rem[30:0], bus.dividend[31]} - bus.divisor;
        default: rem <= rem;
      endcase
    end
  end

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    logic        dbz;
    logic        negr;
    logic [31:0] absb;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic s);
    exp_t e;
    int sa;
    int sbv;
    sa  = a;
    sbv = b;
    e.dbz  = (b == 32'd0);
    e.negr = s & a[31];
    e.absb = (s && b[31]) ? (32'd0 - b) : b;
    if (b == 32'd0) begin
      e.q = 32'hFFFF_FFFF;
      e.r = a;
    end else if (!s) begin
      e.q = a / b;
      e.r = a % b;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      e.q = 32'h8000_0000;
      e.r = 32'd0;
    end else begin
      e.q = sa / sbv;
      e.r = sa % sbv;
    end
    return e;
  endfunction

  // Called at a negedge; start drives that cycle (cycle 0). Returns at cycle 35.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                        input int p1, input int p2);
    exp_t e;
    exp_t got;
    e = model(a, b, s);
    sb.push_back(e);
    bus.startEn    = 1'b1;
    bus.signedOp   = s;
    bus.dividendIn = a;
    bus.divisorIn  = b;
    for (int k = 1; k <= 34; k++) begin
      @(negedge clk);
      chk("busy", {63'd0, bus.busy}, 64'd1);
      chk("done", {63'd0, bus.done}, {63'd0, (k == 34)});
      if (k == 1) begin
        chk("divisor_abs", {32'd0, bus.divisor}, {32'd0, e.absb});
        chk("dbz_latch", {63'd0, bus.divByZero}, {63'd0, e.dbz});
      end
      if (k == 33) begin
        chk("fix_en", {63'd0, bus.remainderEn}, {63'd0, e.negr});
        if (e.negr) begin
          chk("fix_sel", {62'd0, bus.remainderSel}, 64'd1);
        end
      end
      if (k == 34) begin
        if (sb.size() == 0) begin
          chk("sb_empty", 64'd1, 64'd0);
        end else begin
          got = sb.pop_front();
          chk("quotient", {32'd0, bus.quotient}, {32'd0, got.q});
          chk("remainder", {32'd0, rem}, {32'd0, got.r});
          chk("divByZero", {63'd0, bus.divByZero}, {63'd0, got.dbz});
        end
      end
      bus.startEn = (k == p1) || (k == p2);
      if (bus.startEn) begin
        bus.dividendIn = $urandom;
        bus.divisorIn  = $urandom;
        bus.signedOp   = $urandom_range(0, 1);
      end
    end
    @(negedge clk);
    bus.startEn = 1'b0;
    chk("done_after", {63'd0, bus.done}, 64'd0);
    chk("busy_after", {63'd0, bus.busy}, 64'd0);
    chk("q_hold", {32'd0, bus.quotient}, {32'd0, e.q});
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_q"},   {32'd0, bus.quotient}, 64'd0);
    chk({tag, "_dvd"}, {32'd0, bus.dividend}, 64'd0);
    chk({tag, "_dvs"}, {32'd0, bus.divisor},  64'd0);
    chk({tag, "_misc"},
        {58'd0, bus.busy, bus.done, bus.divByZero, bus.remainderEn, bus.remainderSel},
        64'd0);
  endtask

  initial begin
    reset          = 1'b1;
    bus.startEn    = 1'b0;
    bus.signedOp   = 1'b0;
    bus.dividendIn = 32'd0;
    bus.divisorIn  = 32'd0;
    repeat (2) @(negedge clk);
    chk_reset_vals("rst");
    reset = 1'b0;
    @(negedge clk);

    run_op(32'd100, 32'd7, 1'b0, 0, 0);
    run_op(32'hFFFF_FFF9, 32'd2, 1'b1, 0, 0);
    run_op(32'h1234_5678, 32'd0, 1'b1, 0, 0);
    run_op(32'h1234_5678, 32'd0, 1'b0, 0, 0);
    run_op(32'hFFFF_FFF9, 32'd0, 1'b1, 0, 0);
    run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 0, 0);
    run_op(32'hFFFF_FFFF, 32'd1, 1'b0, 0, 0);
    // Starts at cycles 5 and 34 are ignored; the back-to-back op begins at 35.
    run_op(32'd100, 32'd7, 1'b0, 5, 34);
    run_op(32'd1000, 32'd33, 1'b0, 0, 0);

    // Asynchronous reset in the middle of an operation.
    bus.startEn    = 1'b1;
    bus.signedOp   = 1'b0;
    bus.dividendIn = 32'd100;
    bus.divisorIn  = 32'd7;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      bus.startEn = 1'b0;
    end
    chk("busy_pre_abort", {63'd0, bus.busy}, 64'd1);
    #2 reset = 1'b1;
    #1 chk_reset_vals("abort");
    @(negedge clk);
    chk("abort_done", {63'd0, bus.done}, 64'd0);
    reset = 1'b0;
    @(negedge clk);
    run_op(32'd100, 32'd7, 1'b0, 0, 0);

    for (int i = 0; i < 6; i++) begin
      run_op($urandom, $urandom_range(1, 70000), $urandom_range(0, 1), 0, 0);
    end
    run_op(32'h8000_0000, 32'h8000_0000, 1'b1, 0, 0);
    run_op(32'd5, 32'hFFFF_FFFF, 1'b0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
